// File: rtl/bht_update_ctrl_pkg.sv
// Shared types for the BHT update controller.
// Update request bundle and controller state encoding.
package bht_update_ctrl_pkg;

  localparam int VLEN = 64;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bht_ctrl_state_e;

  typedef struct packed {
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_upd_req_t;

endpackage

// File: rtl/rr_arb_onehot.sv
// Round-robin arbiter with one-hot grant.
// Search starts at the pointer; pointer moves past the winner.
module rr_arb_onehot #(
  parameter int NR_REQ = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NR_REQ-1:0] req_i,
  input  logic              en_i,
  output logic [NR_REQ-1:0] gnt_o
);

  localparam int PW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx, win;
  logic          found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      idx = PW'((int'(ptr_q) + i) % NR_REQ);
      if (en_i && !found && req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (found) gnt_o[win] = 1'b1;
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (win == PW'(NR_REQ - 1)) ? '0
            : win + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bht_update_ctrl.sv
// BHT update controller: GHR, gshare indexing,
// update queue and post-reset/flush init sweep.
module bht_update_ctrl
  import bht_update_ctrl_pkg::*;
#(
  parameter  int NR_ENTRIES = 1024,
  parameter  int NR_REQ     = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int IB         = $clog2(NR_ENTRIES)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   debug_mode_i,
  input  logic [VLEN-1:0]        vpc_i,
  output logic [IB-1:0]          pred_idx_o,
  input  logic [NR_REQ-1:0]      upd_valid_i,
  input  logic [NR_REQ*VLEN-1:0] upd_pc_i,
  input  logic [NR_REQ-1:0]      upd_taken_i,
  output logic [NR_REQ-1:0]      upd_ready_o,
  output logic                   tbl_we_o,
  output logic                   tbl_init_o,
  output logic [IB-1:0]          tbl_idx_o,
  output logic                   tbl_taken_o,
  output logic                   busy_o,
  output logic [IB-1:0]          ghr_o
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CW   = PTRW + 1;

  bht_ctrl_state_e state_q, state_d;

  logic [IB-1:0]   sweep_q, sweep_d;
  logic [IB-1:0]   ghr_q, ghr_d;
  logic [IB-1:0]   fifo_pc_q [FIFO_DEPTH];
  logic [IB-1:0]   fifo_pc_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_tk_q, fifo_tk_d;
  logic [PTRW-1:0] rd_q, rd_d;
  logic [PTRW-1:0] wr_q, wr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            full, empty;
  logic            push, pop, arb_en;
  logic [NR_REQ-1:0] gnt;
  bht_upd_req_t    in_req, head;
  logic            unused_bits;

  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);

  // Readiness ignores the same-cycle pop and is
  // held low while reset is asserted.
  assign arb_en = rst_ni && !flush_i && !full;

  rr_arb_onehot #(
    .NR_REQ(NR_REQ)
  ) u_arb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .req_i (upd_valid_i),
    .en_i  (arb_en),
    .gnt_o (gnt)
  );

  assign upd_ready_o = gnt;
  assign pred_idx_o  = ghr_q ^ vpc_i[IB-1:0];
  assign ghr_o       = ghr_q;

  always_comb begin
    in_req = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (gnt[i]) begin
        in_req.pc    = upd_pc_i[i*VLEN +: VLEN];
        in_req.taken = upd_taken_i[i];
      end
    end
  end

  always_comb begin
    head       = '0;
    head.pc    = {{(VLEN-IB){1'b0}}, fifo_pc_q[rd_q]};
    head.taken = fifo_tk_q[rd_q];
  end

  assign unused_bits = ^{vpc_i[VLEN-1:IB],
                         in_req.pc[VLEN-1:IB],
                         head.pc[VLEN-1:IB]};

  assign push = (|gnt) && !debug_mode_i;
  assign pop  = (state_q == RUN) && !empty
             && !flush_i;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = INIT;
    end else if (state_q == INIT &&
                 sweep_q == IB'(NR_ENTRIES - 1)) begin
      state_d = RUN;
    end
  end

  always_comb begin
    fifo_pc_d = fifo_pc_q;
    fifo_tk_d = fifo_tk_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    ghr_d     = ghr_q;
    sweep_d   = sweep_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
      ghr_d   = '0;
      sweep_d = '0;
    end else begin
      if (push) begin
        fifo_pc_d[wr_q] = in_req.pc[IB-1:0];
        fifo_tk_d[wr_q] = in_req.taken;
        wr_d            = wr_q + 1'b1;
      end
      // Index uses the pre-shift GHR.
      if (pop) begin
        rd_d  = rd_q + 1'b1;
        ghr_d = {head.taken, ghr_q[IB-1:1]};
      end
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
      sweep_d = (state_q == INIT) ? sweep_q + 1'b1
              : '0;
    end
  end

  always_comb begin
    tbl_we_o    = 1'b0;
    tbl_init_o  = 1'b0;
    tbl_idx_o   = '0;
    tbl_taken_o = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      INIT: begin
        tbl_we_o   = 1'b1;
        tbl_init_o = 1'b1;
        tbl_idx_o  = sweep_q;
        busy_o     = 1'b1;
      end
      RUN: begin
        if (pop) begin
          tbl_we_o    = 1'b1;
          tbl_idx_o   = ghr_q ^ head.pc[IB-1:0];
          tbl_taken_o = head.taken;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i] <= '0;
      end
      fifo_tk_q <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      ghr_q     <= '0;
      sweep_q   <= '0;
    end else begin
      fifo_pc_q <= fifo_pc_d;
      fifo_tk_q <= fifo_tk_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      ghr_q     <= ghr_d;
      sweep_q   <= sweep_d;
    end
  end

endmodule
